// File: rtl/ft_ctx_reader.sv
// Debug-port context reader: halts the core (if needed), dumps the GPRs and NPC
// into a local snapshot buffer, resumes the core if it halted it, pulses done.
//
//   state | meaning
//   IDLE  | waiting for start_i
//   HALT  | one-cycle halt request pulse
//   HWAIT | waiting for debug_halted_i
//   REQ   | debug read request held until grant
//   RWAIT | waiting for read data
//   RES   | one-cycle resume request pulse
//   DONE  | one-cycle completion pulse
module ft_ctx_reader #(
   parameter int N_REGS  = 32,
   parameter int RESUME  = 1,
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   input  logic [5:0]  rd_idx_i,
   output logic [31:0] rd_data_o,
   output logic        debug_req_o,
   input  logic        debug_gnt_i,
   input  logic        debug_rvalid_i,
   output logic [14:0] debug_addr_o,
   output logic        debug_we_o,
   output logic [31:0] debug_wdata_o,
   input  logic [31:0] debug_rdata_i,
   input  logic        debug_halted_i,
   output logic        debug_halt_o,
   output logic        debug_resume_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_HALT, S_HWAIT, S_REQ, S_RWAIT, S_RES, S_DONE
   } state_t;

   localparam logic [5:0] LAST_IDX = 6'(N_REGS);
   localparam logic [7:0] WAIT_TC  = 8'(TIMEOUT);
   localparam logic [5:0] NPC_SLOT = 6'd32;

   state_t      state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic        own_halt_q, own_halt_d;
   logic        err_q, err_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic [31:0] snap_q [0:32];
   logic [31:0] rd_data_q;

   logic        at_npc;
   logic        wait_tc;
   logic        snap_we;
   logic [5:0]  snap_wsel;
   state_t      finish_state;

   assign at_npc       = (idx_q == LAST_IDX);
   assign wait_tc      = (wcnt_q == 8'd0);
   assign finish_state = ((RESUME != 0) && own_halt_q) ? S_RES : S_DONE;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         idx_q      <= 6'd0;
         own_halt_q <= 1'b0;
         err_q      <= 1'b0;
         wcnt_q     <= WAIT_TC;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         own_halt_q <= own_halt_d;
         err_q      <= err_d;
         wcnt_q     <= wcnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      own_halt_d = own_halt_q;
      err_d      = err_q;
      wcnt_d     = wait_tc ? wcnt_q : wcnt_q - 8'd1;
      snap_we    = 1'b0;
      snap_wsel  = at_npc ? NPC_SLOT : idx_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               err_d      = 1'b0;
               idx_d      = 6'd0;
               own_halt_d = !debug_halted_i;
               state_d    = debug_halted_i ? S_REQ : S_HALT;
            end
         end
         S_HALT: state_d = S_HWAIT;
         S_HWAIT: begin
            if (debug_halted_i) begin
               state_d = S_REQ;
            end else if (wait_tc) begin
               err_d   = 1'b1;
               state_d = finish_state;
            end
         end
         S_REQ: begin
            if (debug_gnt_i) begin
               state_d = S_RWAIT;
            end else if (wait_tc) begin
               err_d   = 1'b1;
               state_d = finish_state;
            end
         end
         S_RWAIT: begin
            if (debug_rvalid_i) begin
               snap_we = 1'b1;
               if (idx_q < LAST_IDX) begin
                  idx_d   = idx_q + 6'd1;
                  state_d = S_REQ;
               end else begin
                  state_d = finish_state;
               end
            end else if (wait_tc) begin
               err_d   = 1'b1;
               state_d = finish_state;
            end
         end
         S_RES:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Every state change restarts the wait timer from its full count.
      if (state_d != state_q) begin
         wcnt_d = WAIT_TC;
      end
   end

   // Slots N_REGS..31 are never written and stay at their reset value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i <= 32; i++) begin
            snap_q[i] <= 32'd0;
         end
      end else if (snap_we) begin
         snap_q[snap_wsel] <= debug_rdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= 32'd0;
      end else if (rd_idx_i <= NPC_SLOT) begin
         rd_data_q <= snap_q[rd_idx_i];
      end else begin
         rd_data_q <= 32'd0;
      end
   end

   assign busy_o         = (state_q != S_IDLE);
   assign done_o         = (state_q == S_DONE);
   assign err_o          = err_q;
   assign rd_data_o      = rd_data_q;
   assign debug_req_o    = (state_q == S_REQ);
   assign debug_addr_o   = (state_q != S_REQ) ? 15'd0 :
                           at_npc ? 15'h2000 : 15'h400 + {7'd0, idx_q, 2'b00};
   assign debug_we_o     = 1'b0;
   assign debug_wdata_o  = 32'd0;
   assign debug_halt_o   = (state_q == S_HALT);
   assign debug_resume_o = (state_q == S_RES);

endmodule
